regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the single-port 8x16 register file in the datapath.
- Supports one write port, two independent combinational read ports (A/B operands) and a synchronous clear of all registers.
- Optional write-to-read bypass.
- Per-register busy scoreboard: the controller marks registers reserved for in-flight results and stalls on hazards.

Parameters:
DATA_W, 16, width of each register and data ports
ADDR_W, 3, register index width; NREGS = 2**ADDR_W registers
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only stored values

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
write  in  1  write enable, sampled at posedge clk
writenum  in  ADDR_W  destination register index
data_in  in  DATA_W  write data
readnum_a  in  ADDR_W  read port A index
data_out_a  out  DATA_W  read port A data (combinational)
readnum_b  in  ADDR_W  read port B index
data_out_b  out  DATA_W  read port B data (combinational)
reserve  in  1  set busy bit of reservenum at posedge clk
reservenum  in  ADDR_W  register to reserve
busy_a  out  1  effective busy state of readnum_a
busy_b  out  1  effective busy state of readnum_b
busy_vec  out  NREGS  registered busy bits, bit i = register i

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n sampled at posedge clk).
- Reset (rst_n=0 at posedge):
  - All NREGS registers <= 0.
  - busy_vec <= 0.
  - write and reserve are ignored that cycle.
  - Reset overrides everything, including an operation in progress.
- Storage:
  - NREGS x DATA_W flops, index decoded as a full binary decode.
  - No register is hardwired; every index writable.
- Write (rst_n=1, write=1 at posedge):
  - reg[writenum] <= data_in.
  - busy_vec[writenum] <= 0 (result has returned).
  - Exactly one register changes.
  - write=0: no register changes; there is no dummy/default flop.
- Reserve (rst_n=1, reserve=1 at posedge): busy_vec[reservenum] <= 1.
- Write and reserve in the same cycle:
  - Different indices: both take effect.
  - Same index: data is written AND busy ends at 1. Reserve wins; this covers issuing a new producer in the cycle the old result retires.
- Reads: pure combinational, zero latency, never X for any in-range index.
  - BYPASS=1, rst_n=1, write=1 and readnum_x==writenum: data_out_x = data_in.
  - Otherwise: data_out_x = reg[readnum_x].
  - BYPASS=0: data_out_x always equals reg[readnum_x]; a new value is visible the cycle after the write edge.
  - Bypass is suppressed while rst_n=0.
  - Both ports may address the same register; each returns the same value.
- busy_x:
  - busy_vec[readnum_x], except it is cleared to 0 when BYPASS=1, rst_n=1, write=1, writenum==readnum_x, and NOT (reserve=1 and reservenum==writenum).
  - So a bypassed operand is not reported as a hazard.
  - BYPASS=0: busy_x = busy_vec[readnum_x].
- Write to a register that is not busy: legal, and its busy bit stays 0.
- Reserve of a register that is already busy: legal and idempotent.
- Latency:
  - Write to stored value: 1 edge.
  - Write to read port: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Reserve to busy_vec: 1 edge.
- Power-up before the first reset: contents undefined. The bench must apply reset first.

Test Plan:
1. Reset clears state: preload reg3=16'hBEEF and busy_vec[3]=1 → hold rst_n=0 for one edge with write=1, writenum=3, data_in=16'h1234 → data_out_a (readnum_a=3) = 0, busy_vec = 0, and the write is discarded.
2. Write/read all regs: write reg i = 16'h1111*i for i=0..7 on successive edges → read A at index i and read B at index 7-i both return the correct values; registers not written in a given cycle are unchanged.
3. Bypass: BYPASS=1, write=1, writenum=5, data_in=16'hA5A5, readnum_a=5, old reg5=16'h0001 → data_out_a=16'hA5A5 in the same cycle. With BYPASS=0 the same stimulus gives 16'h0001 that cycle and 16'hA5A5 on the next.
4. Scoreboard: reserve reg2 → busy_vec=8'h04, busy_a=1 for readnum_a=2. Write reg2=16'h0042 with BYPASS=1 → busy_a=0 combinationally in the write cycle, and busy_vec=8'h00 after the edge.
5. Simultaneous events:
   - Same cycle write reg4=16'h7777 and reserve reg4 → reg4=16'h7777, busy_vec[4]=1, busy_a for readnum_a=4 stays 1 during that cycle.
   - Same cycle write reg1 and reserve reg6 → busy_vec[1]=0, busy_vec[6]=1.
6. Parameter sweep: DATA_W=32, ADDR_W=4 → write reg15=32'hDEADBEEF and read it back on port B; busy_vec is 16 bits wide and reserve of reg15 sets bit 15 only.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with one write port, two
// combinational read ports, optional write-to-read bypass and a
// per-register busy scoreboard used by the controller to stall on hazards.
module regfile_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1,
  localparam int NREGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] readnum_a,
  output logic [DATA_W-1:0] data_out_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reservenum,
  output logic              busy_a,
  output logic              busy_b,
  output logic [NREGS-1:0]  busy_vec
);

  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // Forwarding qualifiers: bypass is only live out of reset with a write pending.
  logic write_live;
  logic hit_a;
  logic hit_b;
  logic reserve_same;

  // Next-state: full binary decode of the write and reserve indices.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (write && (writenum == ADDR_W'(i))) begin
        regs_d[i] = data_in;
        busy_d[i] = 1'b0;
      end
      // Reserve is applied after the write so a same-index reserve leaves busy set.
      if (reserve && (reservenum == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset on purpose; a cleared file is architecturally visible.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Bypass hit detection for both read ports.
  always_comb begin
    write_live   = BYPASS_EN && rst_n && write;
    hit_a        = write_live && (writenum == readnum_a);
    hit_b        = write_live && (writenum == readnum_b);
    reserve_same = reserve && (reservenum == writenum);
  end

  // Read ports: forwarded write data on a hit, stored value otherwise.
  always_comb begin
    data_out_a = hit_a ? data_in : regs_q[readnum_a];
    data_out_b = hit_b ? data_in : regs_q[readnum_b];
  end

  // Effective busy: a bypassed operand is not a hazard unless it is re-reserved this cycle.
  always_comb begin
    busy_a = (hit_a && !reserve_same) ? 1'b0 : busy_q[readnum_a];
    busy_b = (hit_b && !reserve_same) ? 1'b0 : busy_q[readnum_b];
  end

  assign busy_vec = busy_q;

endmodule
